mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencer that drives the MAC accumulator to compute one dot product of VEC_LEN element pairs. It pulls operands from two valid/ready streams, issues Clr/En to the MAC, and waits for the final accumulation. It then returns the 3×DATA_WIDTH result on a valid/ready result port. It sits between the operand buffers and the MAC accumulator. The MAC datapath stays outside this block.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width; MAC result width is 3*DATA_WIDTH
- VEC_LEN, 8, element pairs per dot product; legal range 1..2**DATA_WIDTH, which guarantees no accumulator overflow

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  request a new dot product; sampled only in IDLE
- a_valid  in  1  operand A available
- a_data  in  DATA_WIDTH  operand A
- a_ready  out  1  operand A consumed this cycle
- b_valid  in  1  operand B available
- b_data  in  DATA_WIDTH  operand B
- b_ready  out  1  operand B consumed this cycle
- mac_clr  out  1  to MAC Clr
- mac_en  out  1  to MAC En
- mac_a  out  DATA_WIDTH  to MAC Ain
- mac_b  out  DATA_WIDTH  to MAC Bin
- mac_cout  in  3*DATA_WIDTH  from MAC Cout (registered in MAC)
- res_valid  out  1  result available
- res_data  out  3*DATA_WIDTH  dot-product result
- res_ready  in  1  result consumer accepts
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE -> CLEAR when start=1.
- CLEAR: mac_clr=1 for exactly one cycle, element counter cnt reset to 0, then -> FEED.
- FEED: fire = a_valid && b_valid.
  - a_ready = b_ready = mac_en = fire. Both streams are popped jointly; neither is popped alone.
  - mac_a = a_data and mac_b = b_data, combinationally (MAC samples them on the same edge as En).
  - On fire, cnt increments. When fire occurs with cnt == VEC_LEN-1, go -> DRAIN.
  - Outside FEED, a_ready, b_ready and mac_en are 0. mac_a and mac_b are don't-care, and the implementation drives them 0.
- DRAIN: one cycle so that mac_cout reflects the last accumulation. On exit, res_data <= mac_cout, then -> DONE.
- DONE: res_valid=1 and res_data held stable. When res_valid && res_ready, go -> IDLE.
- start is ignored outside IDLE. There is no queuing.
- mac_clr is never asserted together with mac_en.
- cnt width is $clog2(VEC_LEN+1). cnt never exceeds VEC_LEN-1 in FEED.
- Arithmetic is performed entirely in the MAC. The block adds no width extension or saturation.

## Timing
- Reset (async assert, sync-safe deassert), all registered outputs go to 0:
  - state=IDLE, cnt=0, res_valid=0, res_data=0, busy=0
  - mac_clr=0, mac_en=0, a_ready=0, b_ready=0
- Reset mid-operation aborts immediately with the same values. Partially consumed operands are lost, and the MAC is cleared by its own reset.
- Minimum latency with both streams continuously valid:
  - start sampled at edge E0
  - mac_clr high in cycle after E0
  - mac_en high for VEC_LEN consecutive cycles
  - 1 DRAIN cycle
  - res_valid rises VEC_LEN+3 cycles after E0
- Operand stalls: each cycle with !(a_valid && b_valid) in FEED adds one cycle. mac_en is low in stall cycles.
- Result handshake: res_valid stays high and res_data stays stable until accepted.
  - If res_ready is high on the first DONE cycle, DONE lasts one cycle.
  - A start in that same acceptance cycle is ignored. A new start is honoured from the following IDLE cycle.
- Throughput with res_ready tied high: one dot product per VEC_LEN+4 cycles.

## Test plan
- DATA_WIDTH=8, VEC_LEN=4, A={1,2,3,4}, B={5,6,7,8}, streams always valid, res_ready=1 -> res_data=70, res_valid high VEC_LEN+3=7 cycles after start, exactly 4 mac_en pulses, 1 mac_clr pulse.
- Max operands: A=B=255 ×4 -> res_data=260100 (0x03F804), no overflow. Then run a second back-to-back vector of all 1s -> res_data=4, confirming the clear between runs.
- Stall: b_valid low on alternate cycles with the vector from the first scenario -> res_data=70. No pop on cycles where b_valid=0, and a_ready never high while b_valid=0.
- Backpressure: res_ready held low 5 cycles after res_valid rises -> res_valid and res_data=70 held; start pulses during this wait are ignored. Return to IDLE one cycle after res_ready=1.
- Reset mid-FEED (after 2 of 4 elements): assert rst_n=0 -> all outputs 0 immediately, busy=0. A fresh run of the first scenario's vector then yields 70.
- VEC_LEN=1, A=9, B=7 -> res_data=63, res_valid 4 cycles after start.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mac_seq_ctrl
//
// Sequencer for an external MAC accumulator. It computes one dot product of
// VEC_LEN element pairs, then returns the result on a valid/ready port.
//
// Sequence of states:
//   IDLE  -> CLEAR : on start
//   CLEAR -> FEED  : clears the MAC for one cycle
//   FEED  -> DRAIN : after VEC_LEN joint operand pops
//   DRAIN -> DONE  : captures mac_cout into res_data
//   DONE  -> IDLE  : on result acceptance
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request a dot product (sampled only in IDLE)
//   a_valid/a_data/a_ready  operand A stream
//   b_valid/b_data/b_ready  operand B stream (popped jointly with A)
//   mac_clr, mac_en       MAC Clr / En controls
//   mac_a, mac_b          MAC operand inputs (forwarded in FEED, else 0)
//   mac_cout              registered MAC accumulator output
//   res_valid/res_data/res_ready  dot-product result port
//   busy                  high in every state except IDLE
// -----------------------------------------------------------------------------
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    a_valid,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_ready,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic [DATA_WIDTH-1:0]   mac_a,
    output logic [DATA_WIDTH-1:0]   mac_b,
    input  logic [3*DATA_WIDTH-1:0] mac_cout,
    output logic                    res_valid,
    output logic [3*DATA_WIDTH-1:0] res_data,
    input  logic                    res_ready,
    output logic                    busy
);

    localparam int              CW       = $clog2(VEC_LEN + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [3*DATA_WIDTH-1:0] res_data_reg, res_data_next;
    logic                    fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            res_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            res_data_reg <= res_data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        res_data_next = res_data_reg;
        fire          = 1'b0;
        mac_clr       = 1'b0;
        mac_en        = 1'b0;
        a_ready       = 1'b0;
        b_ready       = 1'b0;
        mac_a         = '0;
        mac_b         = '0;
        res_valid     = 1'b0;
        busy          = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                end
            end

            CLEAR: begin
                mac_clr    = 1'b1;
                cnt_next   = '0;
                state_next = FEED;
            end

            FEED: begin
                // Both streams pop together so A and B elements stay paired.
                fire    = a_valid && b_valid;
                a_ready = fire;
                b_ready = fire;
                mac_en  = fire;
                // The MAC samples its operands on the same edge as En.
                mac_a   = a_data;
                mac_b   = b_data;
                if (fire) begin
                    cnt_next = cnt_reg + CW'(1);
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // mac_cout now includes the last accumulation.
                res_data_next = mac_cout;
                state_next    = DONE;
            end

            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign res_data = res_data_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mac_seq_ctrl
//
// Bench for mac_seq_ctrl. It instantiates one sequencer with VEC_LEN=4 and one
// with VEC_LEN=1. Each instance drives a simple MAC accumulator model. Results
// are checked against dot products computed directly from the operand vectors.
// -----------------------------------------------------------------------------
module tb_mac_seq_ctrl;

    localparam int DW = 8;
    localparam int RW = 3 * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start4, start1;
    logic          a_valid, b_valid, res_ready;
    logic [DW-1:0] a_data, b_data;

    logic          a_ready4, b_ready4, mac_clr4, mac_en4, res_valid4, busy4;
    logic [DW-1:0] mac_a4, mac_b4;
    logic [RW-1:0] mac_cout4, res_data4;

    logic          a_ready1, b_ready1, mac_clr1, mac_en1, res_valid1, busy1;
    logic [DW-1:0] mac_a1, mac_b1;
    logic [RW-1:0] mac_cout1, res_data1;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] va [4];
    logic [DW-1:0] vb [4];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
        .mac_clr(mac_clr4), .mac_en(mac_en4), .mac_a(mac_a4), .mac_b(mac_b4),
        .mac_cout(mac_cout4), .res_valid(res_valid4), .res_data(res_data4),
        .res_ready(res_ready), .busy(busy4)
    );

    mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .mac_clr(mac_clr1), .mac_en(mac_en1), .mac_a(mac_a1), .mac_b(mac_b1),
        .mac_cout(mac_cout1), .res_valid(res_valid1), .res_data(res_data1),
        .res_ready(res_ready), .busy(busy1)
    );

    // MAC accumulator models: Cout is registered, cleared by Clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_cout4 <= '0;
        else if (mac_clr4) mac_cout4 <= '0;
        else if (mac_en4)  mac_cout4 <= mac_cout4 + RW'(mac_a4) * RW'(mac_b4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       mac_cout1 <= '0;
        else if (mac_clr1) mac_cout1 <= '0;
        else if (mac_en1)  mac_cout1 <= mac_cout1 + RW'(mac_a1) * RW'(mac_b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain dot product of the first n pairs.
    function automatic longint dot(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    // One complete dot product on the selected instance (sel=1 -> VEC_LEN=1).
    // mode 0: streams always valid, 1: b_valid low on even cycles,
    // 2: random stalls on either stream. hold = cycles res_ready stays low.
    // Cycle t=0 is the cycle in which start is presented.
    task automatic run(input bit sel, input int n, input int mode, input int hold,
                       input bit check_lat, input string tag);
        int t, idx, en_cnt, clr_cnt, viol, hold_bad, rv_t, acc_t;
        logic          ar, br, en, cl, rv, bs;
        logic [RW-1:0] rd, held;
        longint        exp;
        exp = dot(n);
        t = 0; idx = 0; en_cnt = 0; clr_cnt = 0; viol = 0; hold_bad = 0;
        rv_t = -1; acc_t = -1; held = '0;
        while (acc_t < 0 && t < 200) begin
            rv = sel ? res_valid1 : res_valid4;
            if (rv && rv_t < 0) rv_t = t;
            res_ready = rv && (t >= rv_t + hold);
            // start at t=0, plus spurious pulses while the result waits.
            start4 = !sel && (t == 0 || (rv && !res_ready));
            start1 =  sel && (t == 0 || (rv && !res_ready));
            a_valid = (idx < n) && (mode != 2 || $urandom_range(0, 3) != 0);
            b_valid = (idx < n) && !(mode == 1 && (t % 2) == 0)
                      && (mode != 2 || $urandom_range(0, 3) != 0);
            a_data  = (idx < n) ? va[idx] : DW'($urandom);
            b_data  = (idx < n) ? vb[idx] : DW'($urandom);
            #1;
            ar = sel ? a_ready1 : a_ready4;
            br = sel ? b_ready1 : b_ready4;
            en = sel ? mac_en1  : mac_en4;
            cl = sel ? mac_clr1 : mac_clr4;
            rd = sel ? res_data1 : res_data4;
            if (en) en_cnt++;
            if (cl) clr_cnt++;
            if (cl && en) viol++;
            if (ar && !(a_valid && b_valid)) viol++;
            if (ar !== br || ar !== en) viol++;
            if (rv) begin
                if (t == rv_t) held = rd;
                else if (rd !== held) hold_bad++;
            end
            if (rv && res_ready) acc_t = t;
            @(posedge clk);
            if (ar) idx++;
            @(negedge clk);
            t++;
        end
        start4 = 1'b0; start1 = 1'b0; res_ready = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        bs = sel ? busy1 : busy4;
        rv = sel ? res_valid1 : res_valid4;
        chk({tag, " accepted"}, 64'(acc_t >= 0), 64'd1);
        chk({tag, " res_data"}, 64'(held), 64'(exp));
        chk({tag, " mac_en pulses"}, 64'(en_cnt), 64'(n));
        chk({tag, " mac_clr pulses"}, 64'(clr_cnt), 64'd1);
        chk({tag, " pops"}, 64'(idx), 64'(n));
        chk({tag, " handshake rules"}, 64'(viol), 64'd0);
        chk({tag, " result stable"}, 64'(hold_bad), 64'd0);
        chk({tag, " accept after hold"}, 64'(acc_t - rv_t), 64'(hold));
        chk({tag, " idle after accept"}, {62'd0, bs, rv}, 64'd0);
        if (check_lat) chk({tag, " res_valid latency"}, 64'(rv_t), 64'(n + 3));
        $display("run %s: res=%0d exp=%0d rv_cycle=%0d accept_cycle=%0d",
                 tag, held, exp, rv_t, acc_t);
    endtask

    task automatic chk_zero4(input string tag);
        chk({tag, " busy"}, 64'(busy4), 64'd0);
        chk({tag, " ctrl outs"}, {59'd0, mac_clr4, mac_en4, a_ready4, b_ready4, res_valid4}, 64'd0);
        chk({tag, " res_data"}, 64'(res_data4), 64'd0);
        chk({tag, " mac operands"}, {48'd0, mac_a4, mac_b4}, 64'd0);
    endtask

    initial begin
        int idx;
        rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
        a_data = '0; b_data = '0;
        repeat (2) @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk_zero4("reset");
        chk("reset busy1", 64'(busy1), 64'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vector.
        va = '{8'd1, 8'd2, 8'd3, 8'd4}; vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        run(1'b0, 4, 0, 0, 1'b1, "basic");

        // Max operands, then an all-ones vector back to back.
        va = '{8'd255, 8'd255, 8'd255, 8'd255}; vb = '{8'd255, 8'd255, 8'd255, 8'd255};
        run(1'b0, 4, 0, 0, 1'b1, "max");
        va = '{8'd1, 8'd1, 8'd1, 8'd1}; vb = '{8'd1, 8'd1, 8'd1, 8'd1};
        run(1'b0, 4, 0, 0, 1'b1, "ones");

        // Alternating B stalls.
        va = '{8'd1, 8'd2, 8'd3, 8'd4}; vb = '{8'd5, 8'd6, 8'd7, 8'd8};
        run(1'b0, 4, 1, 0, 1'b0, "stall");

        // Result backpressure for 5 cycles with spurious start pulses.
        run(1'b0, 4, 0, 5, 1'b1, "backpressure");

        // Reset after two of four elements have been consumed.
        idx = 0;
        start4 = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 20 && idx < 2; c++) begin
            a_data = va[idx]; b_data = vb[idx];
            #1;
            @(posedge clk);
            if (a_ready4) idx++;
            @(negedge clk);
            start4 = 1'b0;
        end
        chk("midfeed pops before reset", 64'(idx), 64'd2);
        a_data = va[idx]; b_data = vb[idx];
        rst_n = 1'b0;
        #1;
        chk_zero4("midfeed reset");
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        run(1'b0, 4, 0, 0, 1'b1, "after reset");

        // Random vectors, random stalls and random backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                va[i] = DW'($urandom);
                vb[i] = DW'($urandom);
            end
            run(1'b0, 4, (r == 0) ? 0 : 2, $urandom_range(0, 3), r == 0, $sformatf("random%0d", r));
        end

        // Single-element instance.
        va[0] = 8'd9; vb[0] = 8'd7;
        run(1'b1, 1, 0, 0, 1'b1, "veclen1");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
